// File: rtl/dram_access_sequencer.sv
// DRAM access sequencer: arbitrates bus reads/writes against CAS-before-RAS
// refresh and drives the multiplexed address and RAS/CAS/WE strobes.
module dram_access_sequencer #(
   parameter int ROW_BITS         = 9,
   parameter int T_RCD            = 2,
   parameter int T_CAS            = 2,
   parameter int T_RP             = 2,
   parameter int T_RAS_REF        = 3,
   parameter int REFRESH_INTERVAL = 430
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    req,
   input  logic                    we,
   input  logic [1:0]              be,
   input  logic [2*ROW_BITS-1:0]   addr,
   output logic                    ack,
   output logic                    busy,
   output logic                    latch_en,
   output logic [ROW_BITS-1:0]     dram_addr,
   output logic                    ras_n,
   output logic [1:0]              cas_n,
   output logic                    we_n,
   output logic                    refresh_pending,
   output logic                    refresh_overrun
);

   localparam int T_M1  = (T_RCD > T_CAS) ? T_RCD : T_CAS;
   localparam int T_M2  = (T_RP > T_RAS_REF) ? T_RP : T_RAS_REF;
   localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
   localparam int CW    = $clog2(T_MAX + 1);
   localparam int TW    = $clog2(REFRESH_INTERVAL);

   localparam logic [CW-1:0] RCD_LAST = CW'(T_RCD - 1);
   localparam logic [CW-1:0] CAS_LAST = CW'(T_CAS - 1);
   localparam logic [CW-1:0] RP_LAST  = CW'(T_RP - 1);
   localparam logic [CW-1:0] RAS_LAST = CW'(T_RAS_REF - 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(REFRESH_INTERVAL - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ROW, S_COL, S_PRE, S_REF_CAS, S_REF_RAS
   } state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    start_ref, accept;

   logic [TW-1:0]           tmr_q, tmr_d;
   logic                    wrap;
   logic                    pending_q, pending_d;
   logic                    overrun_q, overrun_d;

   logic                    lat_we_q, lat_we_d;
   logic [1:0]              lat_be_q, lat_be_d;
   logic [2*ROW_BITS-1:0]   lat_addr_q, lat_addr_d;

   logic                    ack_q, ack_d;
   logic                    busy_q, busy_d;
   logic                    latch_en_q, latch_en_d;
   logic [ROW_BITS-1:0]     dram_addr_q, dram_addr_d;
   logic                    ras_n_q, ras_n_d;
   logic [1:0]              cas_n_q, cas_n_d;
   logic                    we_n_q, we_n_d;

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; cnt counts cycles spent in the current state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      start_ref = 1'b0;
      accept    = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (pending_q) begin
               state_d   = S_REF_CAS;
               start_ref = 1'b1;
            end else if (req) begin
               state_d = S_ROW;
               accept  = 1'b1;
            end
         end
         S_ROW: begin
            if (cnt_q == RCD_LAST) begin
               state_d = S_COL;
               cnt_d   = '0;
            end
         end
         S_COL: begin
            if (cnt_q == CAS_LAST) begin
               state_d = S_PRE;
               cnt_d   = '0;
            end
         end
         S_PRE: begin
            if (cnt_q == RP_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         S_REF_CAS: begin
            state_d = S_REF_RAS;
            cnt_d   = '0;
         end
         S_REF_RAS: begin
            if (cnt_q == RAS_LAST) begin
               state_d = S_PRE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Refresh timer, pending/overrun flags and request capture
   always_comb begin
      wrap      = (tmr_q == TMR_LAST);
      tmr_d     = wrap ? '0 : tmr_q + 1'b1;
      // A wrap coinciding with refresh start re-arms pending rather than overrunning.
      pending_d = wrap ? 1'b1 : (start_ref ? 1'b0 : pending_q);
      overrun_d = overrun_q | (wrap & pending_q & ~start_ref);
      lat_we_d   = lat_we_q;
      lat_be_d   = lat_be_q;
      lat_addr_d = lat_addr_q;
      if (accept) begin
         lat_we_d   = we;
         lat_be_d   = be;
         lat_addr_d = addr;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tmr_q      <= '0;
         pending_q  <= 1'b0;
         overrun_q  <= 1'b0;
         lat_we_q   <= 1'b0;
         lat_be_q   <= 2'b00;
         lat_addr_q <= '0;
      end else begin
         tmr_q      <= tmr_d;
         pending_q  <= pending_d;
         overrun_q  <= overrun_d;
         lat_we_q   <= lat_we_d;
         lat_be_q   <= lat_be_d;
         lat_addr_q <= lat_addr_d;
      end
   end

   // Output decode from the upcoming state so the registered strobes line up with it
   always_comb begin
      ras_n_d     = 1'b1;
      cas_n_d     = 2'b11;
      we_n_d      = 1'b1;
      dram_addr_d = dram_addr_q;
      ack_d       = 1'b0;
      latch_en_d  = 1'b0;
      busy_d      = (state_d != S_IDLE);
      case (state_d)
         S_ROW: begin
            ras_n_d     = 1'b0;
            dram_addr_d = lat_addr_d[2*ROW_BITS-1:ROW_BITS];
         end
         S_COL: begin
            ras_n_d     = 1'b0;
            cas_n_d     = ~lat_be_d;
            we_n_d      = ~lat_we_d;
            dram_addr_d = lat_addr_d[ROW_BITS-1:0];
            if (cnt_d == CAS_LAST) begin
               ack_d      = 1'b1;
               latch_en_d = ~lat_we_d;
            end
         end
         S_REF_CAS: begin
            cas_n_d = 2'b00;
         end
         S_REF_RAS: begin
            ras_n_d = 1'b0;
            cas_n_d = 2'b00;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ras_n_q     <= 1'b1;
         cas_n_q     <= 2'b11;
         we_n_q      <= 1'b1;
         dram_addr_q <= '0;
         ack_q       <= 1'b0;
         latch_en_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         ras_n_q     <= ras_n_d;
         cas_n_q     <= cas_n_d;
         we_n_q      <= we_n_d;
         dram_addr_q <= dram_addr_d;
         ack_q       <= ack_d;
         latch_en_q  <= latch_en_d;
         busy_q      <= busy_d;
      end
   end

   assign ras_n           = ras_n_q;
   assign cas_n           = cas_n_q;
   assign we_n            = we_n_q;
   assign dram_addr       = dram_addr_q;
   assign ack             = ack_q;
   assign latch_en        = latch_en_q;
   assign busy            = busy_q;
   assign refresh_pending = pending_q;
   assign refresh_overrun = overrun_q;

endmodule

// File: tb/tb_dram_access_sequencer.sv
// Directed bench: table-driven access vectors plus hand-written refresh,
// refresh-during-access, mid-access reset and overrun sequences.
module tb_dram_access_sequencer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Default-parameter instance
   logic        reset_n, req, we;
   logic [1:0]  be;
   logic [17:0] addr;
   logic        ack, busy, latch_en, ras_n, we_n, refresh_pending, refresh_overrun;
   logic [1:0]  cas_n;
   logic [8:0]  dram_addr;

   // Short-interval, long-CAS instance for overrun
   logic        reset_n2, req2, we2;
   logic [1:0]  be2;
   logic [17:0] addr2;
   logic        ack2, busy2, latch_en2, ras_n2, we_n2, pend2, ovr2;
   logic [1:0]  cas_n2;
   logic [8:0]  dram_addr2;

   dram_access_sequencer dut (
      .clk(clk), .reset_n(reset_n), .req(req), .we(we), .be(be), .addr(addr),
      .ack(ack), .busy(busy), .latch_en(latch_en), .dram_addr(dram_addr),
      .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
      .refresh_pending(refresh_pending), .refresh_overrun(refresh_overrun)
   );

   dram_access_sequencer #(.REFRESH_INTERVAL(16), .T_CAS(40)) dut2 (
      .clk(clk), .reset_n(reset_n2), .req(req2), .we(we2), .be(be2), .addr(addr2),
      .ack(ack2), .busy(busy2), .latch_en(latch_en2), .dram_addr(dram_addr2),
      .ras_n(ras_n2), .cas_n(cas_n2), .we_n(we_n2),
      .refresh_pending(pend2), .refresh_overrun(ovr2)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Expected output word: {ras_n, cas_n, we_n, dram_addr, ack, latch_en, busy}
   typedef struct packed {
      logic        rq;
      logic        w;
      logic [1:0]  b;
      logic [17:0] a;
      logic [15:0] e;
   } vec_t;

   vec_t tbl [21];

   function automatic vec_t mk(input logic rq, input logic w, input logic [1:0] b,
                               input logic [17:0] a, input logic ras, input logic [1:0] cas,
                               input logic wen, input logic [8:0] da, input logic ak,
                               input logic le, input logic bsy);
      vec_t v;
      v.rq = rq; v.w = w; v.b = b; v.a = a;
      v.e  = {ras, cas, wen, da, ak, le, bsy};
      return v;
   endfunction

   function automatic logic [15:0] pack1();
      return {ras_n, cas_n, we_n, dram_addr, ack, latch_en, busy};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got=%h expected=%h", name, cyc, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      // Read 0x2A5C3 be=11, then write 0x0ABCD be=10, then read 0x3FFFF be=00.
      tbl[0]  = mk(1, 0, 2'b11, 18'h2A5C3, 0, 2'b11, 1, 9'h152, 0, 0, 1);
      tbl[1]  = mk(1, 1, 2'b00, 18'h3FFFF, 0, 2'b11, 1, 9'h152, 0, 0, 1);
      tbl[2]  = mk(1, 1, 2'b00, 18'h3FFFF, 0, 2'b00, 1, 9'h1C3, 0, 0, 1);
      tbl[3]  = mk(1, 1, 2'b00, 18'h3FFFF, 0, 2'b00, 1, 9'h1C3, 1, 1, 1);
      tbl[4]  = mk(1, 0, 2'b11, 18'h00000, 1, 2'b11, 1, 9'h1C3, 0, 0, 1);
      tbl[5]  = mk(0, 0, 2'b11, 18'h00000, 1, 2'b11, 1, 9'h1C3, 0, 0, 1);
      tbl[6]  = mk(0, 0, 2'b11, 18'h00000, 1, 2'b11, 1, 9'h1C3, 0, 0, 0);
      tbl[7]  = mk(1, 1, 2'b10, 18'h0ABCD, 0, 2'b11, 1, 9'h055, 0, 0, 1);
      tbl[8]  = mk(1, 0, 2'b11, 18'h00000, 0, 2'b11, 1, 9'h055, 0, 0, 1);
      tbl[9]  = mk(1, 0, 2'b11, 18'h00000, 0, 2'b01, 0, 9'h1CD, 0, 0, 1);
      tbl[10] = mk(1, 0, 2'b11, 18'h00000, 0, 2'b01, 0, 9'h1CD, 1, 0, 1);
      tbl[11] = mk(1, 0, 2'b11, 18'h00000, 1, 2'b11, 1, 9'h1CD, 0, 0, 1);
      tbl[12] = mk(0, 0, 2'b11, 18'h00000, 1, 2'b11, 1, 9'h1CD, 0, 0, 1);
      tbl[13] = mk(0, 0, 2'b11, 18'h00000, 1, 2'b11, 1, 9'h1CD, 0, 0, 0);
      tbl[14] = mk(1, 0, 2'b00, 18'h3FFFF, 0, 2'b11, 1, 9'h1FF, 0, 0, 1);
      tbl[15] = mk(1, 1, 2'b11, 18'h00000, 0, 2'b11, 1, 9'h1FF, 0, 0, 1);
      tbl[16] = mk(1, 1, 2'b11, 18'h00000, 0, 2'b11, 1, 9'h1FF, 0, 0, 1);
      tbl[17] = mk(1, 1, 2'b11, 18'h00000, 0, 2'b11, 1, 9'h1FF, 1, 1, 1);
      tbl[18] = mk(1, 0, 2'b11, 18'h00000, 1, 2'b11, 1, 9'h1FF, 0, 0, 1);
      tbl[19] = mk(0, 0, 2'b11, 18'h00000, 1, 2'b11, 1, 9'h1FF, 0, 0, 1);
      tbl[20] = mk(0, 0, 2'b11, 18'h00000, 1, 2'b11, 1, 9'h1FF, 0, 0, 0);

      reset_n = 1'b0; req = 1'b0; we = 1'b0; be = 2'b00; addr = '0;
      reset_n2 = 1'b0; req2 = 1'b0; we2 = 1'b0; be2 = 2'b00; addr2 = '0;

      // Reset state
      repeat (3) step();
      check("reset_outputs", 32'(pack1()), 32'(16'b1_11_1_000000000_0_0_0));
      check("reset_pending", 32'(refresh_pending), 32'd0);
      check("reset_overrun", 32'(refresh_overrun), 32'd0);

      // Cycle 0: counter is 0 here
      reset_n = 1'b1;
      cyc = 0;
      for (int i = 0; i < 21; i++) begin
         req = tbl[i].rq; we = tbl[i].w; be = tbl[i].b; addr = tbl[i].a;
         step();
         check($sformatf("vec%0d", i), 32'(pack1()), 32'(tbl[i].e));
         if (tbl[i].e[2])
            $display("txn: access completed at cycle %0d (vector %0d)", cyc, i);
      end

      // Idle refresh: pending at cycle 430, then 7-cycle refresh
      req = 1'b0;
      while (!refresh_pending && cyc < 1000) step();
      check("pend_rise_cycle", 32'(cyc), 32'd430);
      begin
         logic [4:0] rexp [7];
         rexp[0] = 5'b1_00_1_1;  // REF_CAS
         rexp[1] = 5'b0_00_1_1;
         rexp[2] = 5'b0_00_1_1;
         rexp[3] = 5'b0_00_1_1;
         rexp[4] = 5'b1_11_1_1;  // PRE
         rexp[5] = 5'b1_11_1_1;
         rexp[6] = 5'b1_11_1_0;  // IDLE
         for (int k = 0; k < 7; k++) begin
            step();
            check($sformatf("refresh_seq%0d", k), 32'({ras_n, cas_n, we_n, busy}), 32'(rexp[k]));
            check($sformatf("refresh_addr%0d", k), 32'(dram_addr), 32'h1FF);
         end
      end
      check("refresh_pend_clr", 32'(refresh_pending), 32'd0);
      check("refresh_no_ovr", 32'(refresh_overrun), 32'd0);
      $display("txn: idle refresh done at cycle %0d", cyc);

      // Refresh during access: counter wraps in the first COL cycle (859)
      while (cyc < 856) step();
      req = 1'b1; we = 1'b0; be = 2'b11; addr = 18'h12345;
      while (cyc < 875) begin
         step();
         case (cyc)
            859: check("rda_pend_before", 32'(refresh_pending), 32'd0);
            860: begin
               check("rda_ack", 32'(ack), 32'd1);
               check("rda_pend_set", 32'(refresh_pending), 32'd1);
            end
            863: check("rda_idle", 32'({busy, refresh_pending}), 32'b01);
            864: check("rda_ref_cas", 32'({ras_n, cas_n, refresh_pending}), 32'b1_00_0);
            870: check("rda_idle2", 32'(busy), 32'd0);
            871: check("rda_row", 32'({ras_n, cas_n, dram_addr}), 32'({1'b0, 2'b11, 9'h091}));
            874: check("rda_ack2", 32'(ack), 32'd1);
            default: ;
         endcase
      end
      req = 1'b0;
      $display("txn: access around refresh done at cycle %0d", cyc);

      // Mid-access reset: access accepted at 1287, reset driven in COL cycle 1290
      while (cyc < 1287) step();
      req = 1'b1; we = 1'b1; be = 2'b11; addr = 18'h00001;
      while (cyc < 1290) step();
      check("mid_pre_state", 32'({ras_n, refresh_pending}), 32'b01);
      reset_n = 1'b0; req = 1'b0;
      step();
      check("mid_reset_outputs", 32'(pack1()), 32'(16'b1_11_1_000000000_0_0_0));
      check("mid_reset_pending", 32'(refresh_pending), 32'd0);
      reset_n = 1'b1;
      cyc = 0;
      while (!refresh_pending && cyc < 1000) step();
      check("mid_counter_restart", 32'(cyc), 32'd430);
      $display("txn: mid-access reset recovered, refresh at %0d", cyc);

      // Overrun on short-interval instance: reset held until cycle 10
      repeat (10) step();
      reset_n2 = 1'b1; req2 = 1'b1; we2 = 1'b0; be2 = 2'b11; addr2 = 18'h00000;
      for (int k = 1; k <= 62; k++) begin
         step();
         case (k)
            15: check("ovr_pend_before", 32'(pend2), 32'd0);
            16: check("ovr_first_wrap", 32'({pend2, ovr2}), 32'b10);
            31: check("ovr_not_yet", 32'(ovr2), 32'd0);
            32: check("ovr_second_wrap", 32'({pend2, ovr2}), 32'b11);
            42: check("ovr_ack", 32'(ack2), 32'd1);
            46: check("ovr_ref_wins", 32'({ras_n2, cas_n2, pend2, ovr2}), 32'b1_00_0_1);
            52: check("ovr_idle", 32'(busy2), 32'd0);
            53: check("ovr_ref_again", 32'({ras_n2, cas_n2}), 32'b1_00);
            60: check("ovr_req_served", 32'({ras_n2, cas_n2, busy2}), 32'b0_11_1);
            default: ;
         endcase
      end
      $display("txn: overrun sequence done");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
